// File: rtl/ov_7670_fb_writer_if.sv
// Frame-buffer write port: show-ahead word with valid/ready handshake.
interface ov_7670_fb_writer_if;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport master (output mem_wvalid, mem_addr, mem_wdata, mem_be, input mem_wready);
  modport slave  (input mem_wvalid, mem_addr, mem_wdata, mem_be, output mem_wready);
endinterface

// File: rtl/ov_7670_fb_writer.sv
// OV7670 frame-buffer writer: RGB888->RGB565, even/odd pixel pairing, word FIFO
// draining over a valid/ready port, with overflow/drop/frame status.
module ov_7670_fb_writer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     cap_we,
  input  logic [18:0]              cap_addr,
  input  logic [23:0]              cap_data,
  input  logic                     flush,
  ov_7670_fb_writer_if.master      mem,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [7:0]               frame_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } word_t;

  word_t       fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic        pend_v;
  logic [18:0] pend_addr;
  logic [15:0] pend_data;

  logic        nxt_pend_v;
  logic [18:0] nxt_pend_addr;
  logic [15:0] nxt_pend_data;
  logic [15:0] pix565;
  logic        push, stale, pop, full, accept, drop_full;
  word_t       push_word, head;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign pix565 = {cap_data[23:19], cap_data[15:10], cap_data[7:3]};

  always_comb begin
    push          = 1'b0;
    stale         = 1'b0;
    push_word     = '0;
    nxt_pend_v    = pend_v;
    nxt_pend_addr = pend_addr;
    nxt_pend_data = pend_data;
    if (cap_we) begin
      if (!cap_addr[0]) begin
        if (pend_v) begin
          push      = 1'b1;
          push_word = '{addr: pend_addr[18:1], data: {16'h0000, pend_data}, be: 4'b0011};
        end
        nxt_pend_v    = 1'b1;
        nxt_pend_addr = cap_addr;
        nxt_pend_data = pix565;
      end else begin
        push       = 1'b1;
        nxt_pend_v = 1'b0;
        if (pend_v && (pend_addr[18:1] == cap_addr[18:1])) begin
          push_word = '{addr: cap_addr[18:1], data: {pix565, pend_data}, be: 4'b1111};
        end else begin
          push_word = '{addr: cap_addr[18:1], data: {pix565, 16'h0000}, be: 4'b1100};
          stale     = pend_v;
        end
      end
    end else if (flush && pend_v) begin
      push       = 1'b1;
      push_word  = '{addr: pend_addr[18:1], data: {16'h0000, pend_data}, be: 4'b0011};
      nxt_pend_v = 1'b0;
    end
  end

  assign full      = (fifo_level == (AW+1)'(DEPTH));
  assign pop       = mem.mem_wvalid && mem.mem_wready;
  assign accept    = push && (!full || pop);
  assign drop_full = push && full && !pop;
  assign drop_inc  = {1'b0, stale} + {1'b0, drop_full};
  assign drop_sum  = {1'b0, drop_cnt} + {15'h0000, drop_inc};

  // Head is masked when empty so the port reads zero after reset.
  assign head           = fifo_q[rd_ptr];
  assign mem.mem_wvalid = (fifo_level != '0);
  assign mem.mem_addr   = mem.mem_wvalid ? head.addr : '0;
  assign mem.mem_wdata  = mem.mem_wvalid ? head.data : '0;
  assign mem.mem_be     = mem.mem_wvalid ? head.be   : '0;

  always_ff @(posedge pclk) begin
    if (accept) fifo_q[wr_ptr] <= push_word;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pend_v     <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      frame_cnt  <= '0;
    end else begin
      pend_v    <= nxt_pend_v;
      pend_addr <= nxt_pend_addr;
      pend_data <= nxt_pend_data;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop_full) overflow <= 1'b1;
      if (drop_inc != 2'b00) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (cap_we && (cap_addr == '0)) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
